// File: rtl/instru_loader_if.sv
// Byte stream in (valid/ready) and word write port out of the loader.
// slave: loader side; master: host/memory side.
interface instru_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );
endinterface

// File: rtl/instru_loader.sv
// Program loader: packs a big-endian byte stream into 32-bit words,
// writes them at consecutive word addresses, holds the CPU until halt.
// Ports: clk, reset (sync, active-high), start, bus (stream + mem
// write port), word_count, busy, done, overflow, cpu_hold.
module instru_loader #(
  parameter int SIZE_IM = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  instru_loader_if.slave  bus,
  output logic [31:0]     word_count,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic            cpu_hold
);

  localparam logic [31:0] HALT = 32'hFC00_0000;
  localparam logic [31:0] LAST = 32'(SIZE_IM - 1);

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t      state_q;
  state_t      state_n;
  logic [1:0]  idx_q;
  logic [31:0] acc_q;
  logic        xfer;
  logic        go;

  // byte_ready is a registered copy of (state == RECV)
  assign xfer = (state_q == RECV) && bus.byte_valid;
  assign go   = start && (state_q == IDLE ||
                          state_q == DONE ||
                          state_q == ERR);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_n = RECV;
      end
      RECV: begin
        if (xfer && idx_q == 2'd3) state_n = WRITE;
      end
      WRITE: begin
        if (acc_q == HALT)           state_n = DONE;
        else if (word_count == LAST) state_n = ERR;
        else                         state_n = RECV;
      end
      default: state_n = IDLE;
    endcase
  end

  // assembly register and byte index
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= 2'd0;
      acc_q <= 32'd0;
    end else if (go || state_q == WRITE) begin
      idx_q <= 2'd0;
    end else if (xfer) begin
      idx_q <= idx_q + 2'd1;
      acc_q <= {acc_q[23:0], bus.byte_in};
    end
  end

  // registered outputs, derived from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.byte_ready <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_addr   <= 32'd0;
      bus.mem_wdata  <= 32'd0;
      word_count     <= 32'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      overflow       <= 1'b0;
      cpu_hold       <= 1'b1;
    end else begin
      bus.byte_ready <= (state_n == RECV);
      bus.mem_we     <= (state_n == WRITE);
      busy           <= (state_n == RECV) ||
                        (state_n == WRITE);
      done           <= (state_n == DONE);
      overflow       <= (state_n == ERR);
      cpu_hold       <= (state_n != DONE);
      // address and word latched in the 4th accept cycle
      if (state_n == WRITE) begin
        bus.mem_addr  <= word_count << 2;
        bus.mem_wdata <= {acc_q[23:0], bus.byte_in};
      end
      if (go)                    word_count <= 32'd0;
      else if (state_q == WRITE) word_count <= word_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_instru_loader.sv
// Directed bench for instru_loader (SIZE_IM=4).
// Checks writes, status flags, handshake and reset behaviour.
module tb_instru_loader;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] word_count;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        cpu_hold;

  instru_loader_if bus ();

  instru_loader #(.SIZE_IM(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus.slave),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [31:0] wa [0:63];
  logic [31:0] wd [0:63];
  int nw = 0;
  int rdy_err = 0;

  // write log and handshake monitor, away from the active edge
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1 && nw < 64) begin
      wa[nw] = bus.mem_addr;
      wd[nw] = bus.mem_wdata;
      nw = nw + 1;
    end
    if (busy === 1'b1 && bus.byte_ready === bus.mem_we)
      rdy_err = rdy_err + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // offer one byte until it is taken; optional idle cycle after
  task automatic send(input logic [7:0] b, input bit gap);
    int n = 0;
    bus.byte_in = b;
    bus.byte_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) begin
        tick();
        break;
      end
      n++;
      if (n > 20) begin
        chk("send_timeout", 32'(n), 32'd0);
        break;
      end
    end
    bus.byte_valid = 1'b0;
    if (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    send(w[31:24], gap);
    send(w[23:16], gap);
    send(w[15:8], gap);
    send(w[7:0], gap);
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (done !== 1'b1 && overflow !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 32'(done | overflow), 32'd1);
  endtask

  task automatic wait_writes(input int target);
    int n = 0;
    while (nw < target && n < 20) begin
      tick();
      n++;
    end
    tick();
    chk("write_wait", 32'(nw), 32'(target));
  endtask

  int nb;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bus.byte_in = 8'h00;
    bus.byte_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", 32'(bus.byte_ready), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_wc", word_count, 32'd0);
    chk("rst_flags", {29'd0, busy, done, overflow}, 32'd0);

    // basic two-word program, no gaps
    nb = nw;
    pulse_start();
    chk("recv_busy", 32'(busy), 32'd1);
    send_word(32'h2008_0005, 1'b0);
    send_word(32'hFC00_0000, 1'b0);
    wait_end("t1_end");
    chk("t1_nw", 32'(nw - nb), 32'd2);
    chk("t1_a0", wa[nb], 32'h0);
    chk("t1_d0", wd[nb], 32'h2008_0005);
    chk("t1_a1", wa[nb+1], 32'h4);
    chk("t1_d1", wd[nb+1], 32'hFC00_0000);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_hold", 32'(cpu_hold), 32'd0);
    chk("t1_wc", word_count, 32'd2);
    chk("t1_ready", 32'(bus.byte_ready), 32'd0);
    // bytes offered in DONE are ignored
    bus.byte_valid = 1'b1;
    repeat (3) tick();
    bus.byte_valid = 1'b0;
    chk("t1_ignored", 32'(nw - nb), 32'd2);

    // restart from DONE, gapped stream
    pulse_start();
    chk("t2_hold", 32'(cpu_hold), 32'd1);
    chk("t2_wc", word_count, 32'd0);
    chk("t2_done", 32'(done), 32'd0);
    nb = nw;
    send_word(32'h2008_0005, 1'b1);
    send_word(32'hFC00_0000, 1'b1);
    wait_end("t2_end");
    chk("t2_nw", 32'(nw - nb), 32'd2);
    chk("t2_a0", wa[nb], 32'h0);
    chk("t2_d0", wd[nb], 32'h2008_0005);
    chk("t2_a1", wa[nb+1], 32'h4);
    chk("t2_d1", wd[nb+1], 32'hFC00_0000);
    chk("t2_wc", word_count, 32'd2);
    chk("rdy_we", 32'(rdy_err), 32'd0);

    // fill all 4 slots without a halt word
    pulse_start();
    nb = nw;
    for (int i = 0; i < 4; i++)
      send_word(32'h0102_0300 + 32'(i), 1'b0);
    wait_end("t3_end");
    chk("t3_nw", 32'(nw - nb), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t3_addr", wa[nb+i], 32'(4 * i));
      chk("t3_data", wd[nb+i], 32'h0102_0300 + 32'(i));
    end
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_hold", 32'(cpu_hold), 32'd1);
    bus.byte_valid = 1'b1;
    repeat (5) begin
      tick();
      chk("t3_ready", 32'(bus.byte_ready), 32'd0);
    end
    bus.byte_valid = 1'b0;
    chk("t3_nomore", 32'(nw - nb), 32'd4);
    chk("t3_wc", word_count, 32'd4);

    // reset mid-word discards the partial word
    pulse_start();
    nb = nw;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("t4_nw", 32'(nw - nb), 32'd0);
    chk("t4_addr", bus.mem_addr, 32'd0);
    chk("t4_data", bus.mem_wdata, 32'd0);
    chk("t4_wc", word_count, 32'd0);
    chk("t4_flags",
        {27'd0, bus.byte_ready, bus.mem_we, busy, done, overflow},
        32'd0);
    chk("t4_hold", 32'(cpu_hold), 32'd1);
    pulse_start();
    send_word(32'h8C01_0004, 1'b0);
    wait_writes(nb + 1);
    chk("t4_a0", wa[nb], 32'h0);
    chk("t4_d0", wd[nb], 32'h8C01_0004);

    // start mid-word is ignored
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    pulse_start();
    send(8'h00, 1'b0);
    send(8'h2A, 1'b0);
    wait_writes(nb + 2);
    chk("t5_a1", wa[nb+1], 32'h4);
    chk("t5_d1", wd[nb+1], 32'h0000_002A);
    chk("t5_wc", word_count, 32'd2);
    send_word(32'hFC00_0000, 1'b0);
    wait_end("t5_end");
    chk("t5_done", 32'(done), 32'd1);

    // restart in DONE, halt as first word
    pulse_start();
    chk("t6_hold", 32'(cpu_hold), 32'd1);
    chk("t6_wc0", word_count, 32'd0);
    nb = nw;
    send_word(32'hFC00_0000, 1'b0);
    wait_end("t6_end");
    chk("t6_nw", 32'(nw - nb), 32'd1);
    chk("t6_a0", wa[nb], 32'h0);
    chk("t6_d0", wd[nb], 32'hFC00_0000);
    chk("t6_done", 32'(done), 32'd1);
    chk("t6_hold0", 32'(cpu_hold), 32'd0);
    chk("t6_wc", word_count, 32'd1);
    chk("rdy_we_all", 32'(rdy_err), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
